// File: rtl/sr_flag_pkg.sv
// Shared definitions for the set/reset flag bank: command encodings, flag
// states and the modulo helper used by the round-robin search.
package sr_flag_pkg;

    // Command encoding: bit1 is the set request, bit0 is the reset request.
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    typedef enum logic [1:0] {
        FLAG_CLR,
        FLAG_SET,
        FLAG_INV
    } flag_state_t;

    function automatic int rr_wrap(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// One set/reset flag with complementary outputs; s=r=1 drives both outputs
// low and keeps them there until a legal set or reset arrives.
module sr_flag_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar
);
    import sr_flag_pkg::*;

    flag_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FLAG_CLR;
        end else if (en) begin
            case ({s, r})
                OP_SET:  state <= FLAG_SET;
                OP_RST:  state <= FLAG_CLR;
                OP_BAD:  state <= FLAG_INV;
                default: state <= state;
            endcase
        end
    end

    // Both outputs decode straight from the state register, so INVALID is 0/0.
    assign q    = (state == FLAG_SET);
    assign qbar = (state == FLAG_CLR);

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting one set/reset command per cycle to a shared
// bank of flags, with one-cycle error pulses for illegal and out-of-range commands.
module sr_flag_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int N_FLAGS = 8,
    localparam int IDX_W   = $clog2(N_FLAGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*IDX_W-1:0]   req_idx,
    input  logic [N_REQ-1:0]         req_s,
    input  logic [N_REQ-1:0]         req_r,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_FLAGS-1:0]       flag_q,
    output logic [N_FLAGS-1:0]       flag_qbar,
    output logic                     err_illegal,
    output logic                     err_range
);
    import sr_flag_pkg::*;

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [N_REQ-1:0]   grant;
    logic               accept;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_s;
    logic               sel_r;
    logic               sel_range;
    logic [N_FLAGS-1:0] en;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant == '0 && req_valid[rr_wrap(int'(rr_ptr), k, N_REQ)]) begin
                grant[rr_wrap(int'(rr_ptr), k, N_REQ)] = 1'b1;
            end
        end
    end

    assign req_ready = rst_n ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        next_ptr = rr_ptr;
        sel_idx  = '0;
        sel_s    = 1'b0;
        sel_r    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                next_ptr = PTR_W'(rr_wrap(i, 1, N_REQ));
                sel_idx  = req_idx[i*IDX_W +: IDX_W];
                sel_s    = req_s[i];
                sel_r    = req_r[i];
            end
        end
    end

    // Compared at full int width so power-of-two banks never alias the limit.
    assign sel_range = (int'(sel_idx) >= N_FLAGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            err_illegal <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= next_ptr;
            end
            err_illegal <= accept && ({sel_s, sel_r} == OP_BAD);
            err_range   <= accept && sel_range;
        end
    end

    for (genvar f = 0; f < N_FLAGS; f++) begin : g_flag
        assign en[f] = accept && (sel_idx == IDX_W'(f));

        sr_flag_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en[f]),
            .s    (sel_s),
            .r    (sel_r),
            .q    (flag_q[f]),
            .qbar (flag_qbar[f])
        );
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: a default 4x8 instance for the main
// behaviour and a 2x5 instance so out-of-range indices are representable.
module tb_sr_flag_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] q;
        logic [7:0] qb;
        logic       ei;
        logic       er;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [3:0]  req_valid = '0;
    logic [11:0] req_idx = '0;
    logic [3:0]  req_s = '0;
    logic [3:0]  req_r = '0;
    logic [3:0]  req_ready;
    logic [7:0]  flag_q;
    logic [7:0]  flag_qbar;
    logic        err_illegal;
    logic        err_range;

    logic [1:0]  v2 = '0;
    logic [5:0]  idx2 = '0;
    logic [1:0]  s2 = '0;
    logic [1:0]  r2 = '0;
    logic [1:0]  rdy2;
    logic [4:0]  fq2;
    logic [4:0]  fqb2;
    logic        ei2;
    logic        er2;

    int total = 0;
    int bad = 0;

    exp_t       exp_q0[$];
    exp_t       exp_q1[$];
    exp_t       pend[2];
    logic       pend_v[2] = '{1'b0, 1'b0};
    logic [7:0] last_q[2] = '{8'h00, 8'h00};
    logic [7:0] last_qb[2] = '{8'hFF, 8'h1F};

    sr_flag_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_s      (req_s),
        .req_r      (req_r),
        .req_ready  (req_ready),
        .flag_q     (flag_q),
        .flag_qbar  (flag_qbar),
        .err_illegal(err_illegal),
        .err_range  (err_range)
    );

    sr_flag_arbiter #(.N_REQ(2), .N_FLAGS(5)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (v2),
        .req_idx    (idx2),
        .req_s      (s2),
        .req_r      (r2),
        .req_ready  (rdy2),
        .flag_q     (fq2),
        .flag_qbar  (fqb2),
        .err_illegal(ei2),
        .err_range  (er2)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: results of last cycle's handshake, then this cycle's grant.
    task automatic monitor_step(input int id, input logic [3:0] hs, input logic [7:0] fq,
                                input logic [7:0] fqb, input logic ei, input logic er);
        exp_t e;
        int   depth;
        if (!rst_n) begin
            if (id == 0) exp_q0.delete();
            else         exp_q1.delete();
            pend_v[id]  = 1'b0;
            last_q[id]  = 8'h00;
            last_qb[id] = (id == 0) ? 8'hFF : 8'h1F;
            return;
        end
        if (pend_v[id]) begin
            check_output($sformatf("dut%0d flag_q", id), 32'(fq), 32'(pend[id].q));
            check_output($sformatf("dut%0d flag_qbar", id), 32'(fqb), 32'(pend[id].qb));
            check_output($sformatf("dut%0d err_illegal", id), 32'(ei), 32'(pend[id].ei));
            check_output($sformatf("dut%0d err_range", id), 32'(er), 32'(pend[id].er));
            last_q[id]  = pend[id].q;
            last_qb[id] = pend[id].qb;
        end else begin
            check_output($sformatf("dut%0d flag_q hold", id), 32'(fq), 32'(last_q[id]));
            check_output($sformatf("dut%0d flag_qbar hold", id), 32'(fqb), 32'(last_qb[id]));
            check_output($sformatf("dut%0d err idle", id), 32'({ei, er}), 32'(0));
        end
        pend_v[id] = 1'b0;
        if (hs != '0) begin
            depth = (id == 0) ? exp_q0.size() : exp_q1.size();
            if (depth == 0) begin
                check_output($sformatf("dut%0d unexpected grant", id), 32'(hs), 32'(0));
            end else begin
                if (id == 0) e = exp_q0.pop_front();
                else         e = exp_q1.pop_front();
                check_output($sformatf("dut%0d grant", id), 32'(hs), 32'(e.grant));
                pend[id]   = e;
                pend_v[id] = 1'b1;
            end
        end
    endtask

    always @(negedge clk)
        monitor_step(0, req_valid & req_ready, flag_q, flag_qbar, err_illegal, err_range);

    always @(negedge clk)
        monitor_step(1, {2'b00, v2 & rdy2}, {3'b000, fq2}, {3'b000, fqb2}, ei2, er2);

    // Single command on the main instance; expects to be called just after a rising edge.
    task automatic send_main(input int req, input int idx, input logic s, input logic r,
                             input logic [7:0] eq, input logic [7:0] eqb,
                             input logic ei, input logic er);
        exp_q0.push_back('{grant: 4'(1 << req), q: eq, qb: eqb, ei: ei, er: er});
        req_valid           = '0;
        req_valid[req]      = 1'b1;
        req_idx[req*3 +: 3] = 3'(idx);
        req_s[req]          = s;
        req_r[req]          = r;
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic send_small(input int req, input int idx, input logic s, input logic r,
                              input logic [7:0] eq, input logic [7:0] eqb,
                              input logic ei, input logic er);
        exp_q1.push_back('{grant: 4'(1 << req), q: eq, qb: eqb, ei: ei, er: er});
        v2               = '0;
        v2[req]          = 1'b1;
        idx2[req*3 +: 3] = 3'(idx);
        s2[req]          = s;
        r2[req]          = r;
        @(posedge clk);
        #1;
        v2 = '0;
    endtask

    task automatic apply_stimulus();
        // Reset with requests pending: nothing may be granted.
        rst_n     = 1'b0;
        req_valid = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset ready", 32'(req_ready), 32'(0));
        check_output("reset flag_q", 32'(flag_q), 32'(8'h00));
        check_output("reset flag_qbar", 32'(flag_qbar), 32'(8'hFF));
        check_output("reset errs", 32'({err_illegal, err_range}), 32'(0));
        req_valid = '0;
        rst_n     = 1'b1;
        #1;
        check_output("post-reset flag_qbar", 32'(flag_qbar), 32'(8'hFF));

        send_main(0, 3, 1'b1, 1'b0, 8'h08, 8'hF7, 1'b0, 1'b0);
        send_main(0, 3, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
        // Hold from requester 3 wraps the pointer back to 0.
        send_main(3, 7, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            req_idx[i*3 +: 3] = 3'(i);
            req_s[i]          = 1'b1;
            req_r[i]          = 1'b0;
        end
        exp_q0.push_back('{grant: 4'b0001, q: 8'h01, qb: 8'hFE, ei: 1'b0, er: 1'b0});
        exp_q0.push_back('{grant: 4'b0010, q: 8'h03, qb: 8'hFC, ei: 1'b0, er: 1'b0});
        exp_q0.push_back('{grant: 4'b0100, q: 8'h07, qb: 8'hF8, ei: 1'b0, er: 1'b0});
        exp_q0.push_back('{grant: 4'b1000, q: 8'h0F, qb: 8'hF0, ei: 1'b0, er: 1'b0});
        exp_q0.push_back('{grant: 4'b0001, q: 8'h0F, qb: 8'hF0, ei: 1'b0, er: 1'b0});
        req_valid = 4'hF;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        req_valid = '0;

        send_main(2, 5, 1'b1, 1'b1, 8'h0F, 8'hD0, 1'b1, 1'b0);
        send_main(2, 5, 1'b0, 1'b0, 8'h0F, 8'hD0, 1'b0, 1'b0);
        send_main(2, 5, 1'b1, 1'b0, 8'h2F, 8'hD0, 1'b0, 1'b0);

        // Park the pointer on 1, then race a set (req 1) and reset (req 2) on flag 0.
        send_main(0, 0, 1'b0, 1'b0, 8'h2F, 8'hD0, 1'b0, 1'b0);
        req_idx[3 +: 3] = 3'd0;
        req_s[1]        = 1'b1;
        req_r[1]        = 1'b0;
        req_idx[6 +: 3] = 3'd0;
        req_s[2]        = 1'b0;
        req_r[2]        = 1'b1;
        exp_q0.push_back('{grant: 4'b0010, q: 8'h2F, qb: 8'hD0, ei: 1'b0, er: 1'b0});
        exp_q0.push_back('{grant: 4'b0100, q: 8'h2E, qb: 8'hD1, ei: 1'b0, er: 1'b0});
        req_valid = 4'b0110;
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        @(posedge clk);
        #1;
        req_valid = '0;

        // Burst with pointer at 3, then an asynchronous reset between edges.
        for (int i = 0; i < 4; i++) begin
            req_idx[i*3 +: 3] = 3'(i);
            req_s[i]          = 1'b1;
            req_r[i]          = 1'b0;
        end
        exp_q0.push_back('{grant: 4'b1000, q: 8'h2E, qb: 8'hD1, ei: 1'b0, er: 1'b0});
        exp_q0.push_back('{grant: 4'b0001, q: 8'h2F, qb: 8'hD0, ei: 1'b0, er: 1'b0});
        req_valid = 4'hF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("async reset flag_q", 32'(flag_q), 32'(8'h00));
        check_output("async reset flag_qbar", 32'(flag_qbar), 32'(8'hFF));
        check_output("async reset ready", 32'(req_ready), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b1001;
        rst_n     = 1'b1;
        exp_q0.push_back('{grant: 4'b0001, q: 8'h01, qb: 8'hFE, ei: 1'b0, er: 1'b0});
        @(posedge clk);
        #1;
        req_valid = '0;

        // Small instance: indices 5..7 are out of range for a 5-flag bank.
        send_small(0, 6, 1'b1, 1'b0, 8'h00, 8'h1F, 1'b0, 1'b1);
        send_small(1, 7, 1'b1, 1'b1, 8'h00, 8'h1F, 1'b1, 1'b1);
        send_small(0, 4, 1'b1, 1'b0, 8'h10, 8'h0F, 1'b0, 1'b0);
    endtask

    initial begin
        apply_stimulus();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 20 && (exp_q0.size() + exp_q1.size() != 0 || pend_v[0] || pend_v[1]); i++)
            @(posedge clk);
        #1;
        check_output("scoreboard drain", 32'(exp_q0.size() + exp_q1.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
